keypad_scan_fifo: RTL and testbench

Parametrised matrix-keypad scanner with debounce, key-code FIFO and optional auto-repeat. It drives ROWS×COLS keypad columns active-low, samples active-low row returns on a 1 ms-class tick, and debounces press and release. Each detected key is encoded as a binary index and queued for a valid/ready consumer, such as a seven-segment driver or a CPU register bank. It replaces the fixed 4×4 single-register scanner, which lost keys when the consumer was slow.

---
 rtl/keypad_scan_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// keypad_scan_fifo - debounced active-low matrix keypad scanner feeding a
// valid/ready key-code FIFO; define KEYPAD_REPEAT_EN for auto-repeat. Rev 1.0
// ============================================================================
module keypad_scan_fifo #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int TICK_CYC   = 50000,
    parameter  int DEB_TICKS  = 20,
    parameter  int FIFO_DEPTH = 4,
    parameter  int REP_DELAY  = 500,
    parameter  int REP_RATE   = 100,
    localparam int CODE_W     = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              ovf
);
    localparam int TC_W  = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int DEB_W = $clog2(DEB_TICKS + 1);
    localparam int COL_W = $clog2(COLS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;

    logic [ROWS-1:0]   r_row_meta, r_row_sync;
    logic [TC_W-1:0]   r_tick_cnt;
    logic              w_tick, w_any_low;
    logic [1:0]        r_state, w_state_nxt;
    logic [DEB_W-1:0]  r_deb_cnt, w_deb_nxt;
    logic [COL_W-1:0]  r_col_idx, w_col_idx_nxt;
    logic              w_scan_push, w_push, w_pop, w_full, w_wr_en;
    logic [CODE_W-1:0] w_code, w_push_code;

    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CODE_W-1:0] r_head;

    // Row returns are asynchronous to clk: two-stage synchroniser, idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
            r_tick_cnt <= '0;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    assign w_tick    = (r_tick_cnt == TC_W'(TICK_CYC - 1));
    assign w_any_low = ~&r_row_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_deb_cnt <= '0;
            r_col_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_nxt;
            r_col_idx <= w_col_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_deb_nxt     = r_deb_cnt;
        w_col_idx_nxt = r_col_idx;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_any_low) begin
                        w_deb_nxt = '0;
                    end else if (r_deb_cnt == DEB_W'(DEB_TICKS - 1)) begin
                        w_deb_nxt     = '0;
                        w_col_idx_nxt = '0;
                        w_state_nxt   = S_SCAN;
                    end else begin
                        w_deb_nxt = r_deb_cnt + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_any_low) begin
                        w_state_nxt = S_HELD;
                    end else if (r_col_idx == COL_W'(COLS - 1)) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 1'b1;
                    end
                end
                S_HELD: begin
                    if (w_any_low) begin
                        w_deb_nxt = '0;
                    end else if (r_deb_cnt == DEB_W'(DEB_TICKS - 1)) begin
                        w_deb_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_deb_nxt = r_deb_cnt + 1'b1;
                    end
                end
                default: begin
                    w_deb_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        col         = (r_state == S_SCAN) ? ~(COLS'(1) << r_col_idx) : '0;
        key_held    = (r_state == S_HELD);
        w_scan_push = w_tick && (r_state == S_SCAN) && w_any_low;
    end

    // Lowest-numbered low row wins when several rows answer the same column.
    always_comb begin
        w_code = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r_row_sync[i]) begin
                w_code = CODE_W'(i * COLS) + CODE_W'(r_col_idx);
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0]  r_rep_cnt;
    logic [CODE_W-1:0] r_rep_code;
    logic              w_rep_push;

    // Countdown to the next repeat; any high tick restarts the initial delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt  <= '0;
            r_rep_code <= '0;
        end else if (w_scan_push) begin
            r_rep_cnt  <= REP_W'(REP_DELAY);
            r_rep_code <= w_code;
        end else if (w_tick && (r_state == S_HELD)) begin
            if (!w_any_low) begin
                r_rep_cnt <= REP_W'(REP_DELAY);
            end else if (r_rep_cnt == REP_W'(1)) begin
                r_rep_cnt <= REP_W'(REP_RATE);
            end else begin
                r_rep_cnt <= r_rep_cnt - 1'b1;
            end
        end
    end

    assign w_rep_push  = w_tick && (r_state == S_HELD) && w_any_low && (r_rep_cnt == REP_W'(1));
    assign w_push      = w_scan_push | w_rep_push;
    assign w_push_code = w_rep_push ? r_rep_code : w_code;
`else
    assign w_push      = w_scan_push;
    assign w_push_code = w_code;
`endif

    assign key_valid = (r_count != '0);
    assign key_code  = r_head;
    assign w_pop     = key_valid & key_ready;
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign ovf       = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_code;
        end
    end

    // r_head mirrors the entry at the post-update read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                if (r_count > CNT_W'(1)) begin
                    r_head <= r_mem[r_rd_ptr + 1'b1];
                end else if (w_wr_en) begin
                    r_head <= w_push_code;
                end
            end else if ((r_count == '0) && w_wr_en) begin
                r_head <= w_push_code;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// tb_keypad_scan_fifo - keypad model + queue reference for keypad_scan_fifo.
// Rev 1.0
// ============================================================================
module tb_keypad_scan_fifo;
    localparam int ROWS = 4, COLS = 4, TICK_CYC = 10, DEB = 3, DEPTH = 4;
    localparam int REP_DELAY = 5, REP_RATE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_ready = 1'b0, key_held, ovf;

    logic       pr_en = 1'b0;
    logic [1:0] pr_r  = '0, pr_c = '0;

    int tests = 0, fails = 0, ovf_seen = 0, tb_cnt = 0;
    int exp_q[$];

    keypad_scan_fifo #(
        .ROWS(ROWS), .COLS(COLS), .TICK_CYC(TICK_CYC), .DEB_TICKS(DEB),
        .FIFO_DEPTH(DEPTH), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
    ) u_dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Single pressed key: its row is pulled low whenever its column is driven low.
    always_comb begin
        row = '1;
        if (pr_en && !col[pr_c]) row[pr_r] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == TICK_CYC - 1) ? 0 : tb_cnt + 1;
    end

    always @(negedge clk) if (ovf === 1'b1) ovf_seen++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_tick();
        do @(negedge clk); while (tb_cnt != TICK_CYC - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) next_tick();
    endtask

    // Full press/release of one key; reference queue gets the code or an overflow.
    task automatic press_key(input int r, input int c, input int eh, input int er, inout int exp_ovf);
        pr_r = 2'(r); pr_c = 2'(c); pr_en = 1'b1;
        ticks(DEB + c + 1 + eh);
        if (exp_q.size() < DEPTH) exp_q.push_back(r * COLS + c);
        else exp_ovf++;
        pr_en = 1'b0;
        ticks(DEB + er);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (col !== 4'h0) begin fails++; $display("FAIL reset_col: got %h expected 0", col); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h expected 0", key_code); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %b expected 0", key_held); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_press_latency();
        next_tick();
        pr_r = 2'd2; pr_c = 2'd1; pr_en = 1'b1;
        ticks(DEB);
        tests++; if (col !== 4'b1110) begin fails++; $display("FAIL lat_col0: got %b expected 1110", col); end
        ticks(1);
        tests++; if (col !== 4'b1101) begin fails++; $display("FAIL lat_col1: got %b expected 1101", col); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL lat_early: got %b expected 0", key_valid); end
        ticks(1);
        tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL lat_valid: got %b expected 1", key_valid); end
        tests++; if (key_code !== 4'd9) begin fails++; $display("FAIL lat_code: got %0d expected 9", key_code); end
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL lat_held: got %b expected 1", key_held); end
        tests++; if (col !== 4'b0000) begin fails++; $display("FAIL lat_held_col: got %b expected 0000", col); end
        pr_en = 1'b0;
        ticks(DEB - 1);
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL rel_early: got %b expected 1", key_held); end
        ticks(1);
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL rel_done: got %b expected 0", key_held); end
        key_ready = 1'b1;
        @(posedge clk); #1;
        key_ready = 1'b0;
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL lat_pop: got %b expected 0", key_valid); end
    endtask

    task automatic test_bounce();
        next_tick();
        pr_r = 2'd1; pr_c = 2'd0; pr_en = 1'b1;
        ticks(2); pr_en = 1'b0; ticks(1); pr_en = 1'b1;
        ticks(DEB);
        tests++; if (key_valid !== 1'b0 || col !== 4'b1110) begin fails++; $display("FAIL bounce_scan: got valid=%b col=%b expected 0/1110", key_valid, col); end
        ticks(1);
        tests++; if (key_valid !== 1'b1 || key_code !== 4'd4) begin fails++; $display("FAIL bounce_push: got valid=%b code=%0d expected 1/4", key_valid, key_code); end
        pr_en = 1'b0; ticks(DEB);
        key_ready = 1'b1; @(posedge clk); #1; key_ready = 1'b0;
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL bounce_single: got %b expected 0", key_valid); end
        // too-short press never leaves IDLE
        pr_en = 1'b1; ticks(2); pr_en = 1'b0; ticks(DEB + 2);
        tests++; if (key_valid !== 1'b0 || key_held !== 1'b0 || col !== 4'h0) begin fails++; $display("FAIL short_press: got valid=%b held=%b col=%b expected 0/0/0000", key_valid, key_held, col); end
        // release during SCAN: every column misses, back to IDLE
        pr_r = 2'd0; pr_c = 2'd2; pr_en = 1'b1;
        ticks(DEB); pr_en = 1'b0;
        ticks(COLS - 1);
        tests++; if (col !== 4'b0111) begin fails++; $display("FAIL glitch_last_col: got %b expected 0111", col); end
        ticks(1);
        tests++; if (col !== 4'h0 || key_valid !== 1'b0) begin fails++; $display("FAIL glitch_idle: got col=%b valid=%b expected 0000/0", col, key_valid); end
    endtask

    task automatic test_overflow();
        bit used[16];
        int code, base, exp_ovf;
        base = ovf_seen; exp_ovf = 0; exp_q.delete(); key_ready = 1'b0;
        for (int i = 0; i < 16; i++) used[i] = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            do code = $urandom_range(0, 15); while (used[code]);
            used[code] = 1'b1;
            press_key(code / COLS, code % COLS, 0, 0, exp_ovf);
        end
        tests++; if (ovf_seen - base != exp_ovf) begin fails++; $display("FAIL ovf_count: got %0d expected %0d", ovf_seen - base, exp_ovf); end
        key_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            tests++; if (key_valid !== 1'b1 || key_code !== 4'(exp_q[0])) begin fails++; $display("FAIL ovf_order[%0d]: got valid=%b code=%0d expected 1/%0d", i, key_valid, key_code, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1; key_ready = 1'b0;
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL ovf_drained: got %b expected 0", key_valid); end
    endtask

    task automatic test_full_push_pop();
        int code, base, exp_ovf, r, c;
        base = ovf_seen; exp_ovf = 0; exp_q.delete(); key_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            code = $urandom_range(0, 15);
            press_key(code / COLS, code % COLS, 0, 0, exp_ovf);
        end
        code = $urandom_range(0, 15); r = code / COLS; c = code % COLS;
        pr_r = 2'(r); pr_c = 2'(c); pr_en = 1'b1;
        ticks(DEB + c);
        repeat (TICK_CYC - 1) @(posedge clk);
        #1; key_ready = 1'b1;
        @(negedge clk);
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL full_pushpop_ovf: got %b expected 0", ovf); end
        @(posedge clk); #1; key_ready = 1'b0;
        void'(exp_q.pop_front()); exp_q.push_back(code);
        pr_en = 1'b0; ticks(DEB);
        key_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            tests++; if (key_valid !== 1'b1 || key_code !== 4'(exp_q[0])) begin fails++; $display("FAIL full_pushpop_order[%0d]: got valid=%b code=%0d expected 1/%0d", i, key_valid, key_code, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1; key_ready = 1'b0;
        tests++; if (key_valid !== 1'b0 || ovf_seen != base) begin fails++; $display("FAIL full_pushpop_count: got valid=%b ovf=%0d expected 0/0", key_valid, ovf_seen - base); end
    endtask

    task automatic test_random();
        int code, exp_ovf, n;
        exp_ovf = 0; exp_q.delete();
        for (int round = 0; round < 3; round++) begin
            key_ready = 1'b0;
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                code = $urandom_range(0, 15);
                press_key(code / COLS, code % COLS, $urandom_range(0, 3), $urandom_range(0, 2), exp_ovf);
            end
            for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
                @(posedge clk); #1; key_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (key_valid === 1'b1 && key_ready) begin
                    tests++; if (key_code !== 4'(exp_q[0])) begin fails++; $display("FAIL rand_code r%0d: got %0d expected %0d", round, key_code, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            @(posedge clk); #1; key_ready = 1'b0;
            tests++; if (exp_q.size() != 0 || key_valid !== 1'b0) begin fails++; $display("FAIL rand_drain r%0d: got left=%0d valid=%b expected 0/0", round, exp_q.size(), key_valid); end
        end
    endtask

    task automatic test_reset_mid_scan();
        int code, exp_ovf, r;
        exp_ovf = 0; exp_q.delete(); key_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            code = $urandom_range(0, 15);
            press_key(code / COLS, code % COLS, 0, 0, exp_ovf);
        end
        r = $urandom_range(0, 3);
        pr_r = 2'(r); pr_c = 2'd3; pr_en = 1'b1;
        ticks(DEB + 1);
        rst = 1'b1; #1;
        tests++; if (col !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin fails++; $display("FAIL rst_mid: got col=%b valid=%b held=%b expected 0000/0/0", col, key_valid, key_held); end
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        ticks(DEB + 3);
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rst_deb_early: got %b expected 0", key_valid); end
        ticks(1);
        tests++; if (key_valid !== 1'b1 || key_code !== 4'(r * COLS + 3)) begin fails++; $display("FAIL rst_repress: got valid=%b code=%0d expected 1/%0d", key_valid, key_code, r * COLS + 3); end
        pr_en = 1'b0; ticks(DEB);
        key_ready = 1'b1; @(posedge clk); #1; key_ready = 1'b0;
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rst_single: got %b expected 0", key_valid); end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int n_hold = 0, n_rel = 0, bad = 0;
        next_tick();
        pr_r = 2'd0; pr_c = 2'd0; pr_en = 1'b1; key_ready = 1'b1;
        // 1 scan push + repeats at held ticks REP_DELAY, +REP_RATE, ... within 12 ticks
        repeat ((DEB + 1 + 12) * TICK_CYC) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin n_hold++; if (key_code !== 4'd0) bad++; end
        end
        @(posedge clk); #1; pr_en = 1'b0;
        repeat ((DEB + 2) * TICK_CYC) begin
            @(negedge clk);
            if (key_valid === 1'b1) n_rel++;
        end
        key_ready = 1'b0;
        tests++; if (n_hold != 5) begin fails++; $display("FAIL rep_count: got %0d expected 5", n_hold); end
        tests++; if (bad != 0) begin fails++; $display("FAIL rep_code: got %0d wrong codes expected 0", bad); end
        tests++; if (n_rel != 0) begin fails++; $display("FAIL rep_after_release: got %0d expected 0", n_rel); end
    endtask
`endif

    initial begin
        test_reset();
        test_press_latency();
        test_bounce();
        test_overflow();
        test_full_push_pop();
        test_random();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
